// File: rtl/par_buffered_sink_pkg.sv
// Shared widths and LFSR helpers for the buffered NoC endpoint sink.
package par_buffered_sink_pkg;

    localparam int unsigned PAYLOAD_SIZE = 8;
    localparam int unsigned ADDR_BITS    = 4;
    localparam int unsigned LFSR_W       = 16;

    // Fibonacci taps at bit positions 16,14,13,11 (1-based)
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sink_fifo.sv
// Circular FIFO with separate occupancy counter; pointers wrap modulo DEPTH.
module sink_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data_c,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [$clog2(DEPTH):0]   occ_next_c,
    output logic                     empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty_c    = (occupancy == '0);
    assign wr_en      = push && (occupancy != OCC_W'(DEPTH));
    assign rd_en      = pop && !empty_c;
    assign rd_data_c  = mem[rd_ptr];
    assign occ_next_c = occupancy + OCC_W'(wr_en) - OCC_W'(rd_en);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            occupancy <= occ_next_c;
        end
    end

    // Storage needs no reset: contents are only visible through occupancy
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/par_buffered_sink.sv
// NoC endpoint sink: buffers accepted flits, drains them at an LFSR-gated rate, keeps statistics.
module par_buffered_sink
    import par_buffered_sink_pkg::*;
#(
    parameter int          ID          = -1,
    parameter int unsigned HOSPITALITY = 255,
    parameter int unsigned MODE        = 1,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned PAYLOAD_W   = PAYLOAD_SIZE,
    parameter int unsigned ADDR_W      = ADDR_BITS,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [PAYLOAD_W+ADDR_W-1:0] item_in,
    input  logic                        valid,
    output logic                        channel_busy,
    output logic [$clog2(DEPTH):0]      occupancy,
    output logic [PAYLOAD_W-1:0]        last_payload,
    output logic [CNT_W-1:0]            rx_count,
    output logic [CNT_W-1:0]            misroute_count
);

    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    localparam logic [31:0]       ID_BITS   = 32'(ID);
    localparam logic [ADDR_W-1:0] MY_ADDR   = ID_BITS[ADDR_W-1:0];
    localparam logic [LFSR_W-1:0] SEED_RAW  = {ID_BITS[7:0], 8'hA5};
    localparam logic [LFSR_W-1:0] LFSR_SEED = (SEED_RAW == '0) ? 16'h0001 : SEED_RAW;
    // Exclusive bound avoids a constant-true compare when HOSPITALITY is 255
    localparam logic [8:0]        HOSP_LIM  = 9'(HOSPITALITY) + 9'd1;

    logic [LFSR_W-1:0]    lfsr;
    logic [PAYLOAD_W-1:0] payload_c;
    logic [ADDR_W-1:0]    dest_c;
    logic [PAYLOAD_W-1:0] head_c;
    logic [OCC_W-1:0]     occ_next_c;
    logic                 empty_c;
    logic                 drain_en_c;
    logic                 push_c;
    logic                 pop_c;

    assign payload_c  = item_in[ADDR_W +: PAYLOAD_W];
    assign dest_c     = item_in[ADDR_W-1:0];
    assign drain_en_c = (MODE == 0) || ({1'b0, lfsr[7:0]} < HOSP_LIM);
    assign push_c     = valid && !channel_busy;
    assign pop_c      = drain_en_c && !empty_c;

    sink_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PAYLOAD_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_c),
        .pop        (pop_c),
        .wr_data    (payload_c),
        .rd_data_c  (head_c),
        .occupancy  (occupancy),
        .occ_next_c (occ_next_c),
        .empty_c    (empty_c)
    );

    // Free-running drain-rate LFSR
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr <= LFSR_SEED;
        else        lfsr <= lfsr_step(lfsr);
    end

    // Busy is registered from next fill level so a push never meets a full FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            channel_busy <= 1'b0;
            last_payload <= '0;
        end else begin
            channel_busy <= (occ_next_c == OCC_W'(DEPTH));
            if (pop_c) last_payload <= head_c;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_count       <= '0;
            misroute_count <= '0;
        end else if (push_c) begin
            if (rx_count != '1) rx_count <= rx_count + CNT_W'(1);
            if ((dest_c != MY_ADDR) && (misroute_count != '1))
                misroute_count <= misroute_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_par_buffered_sink.sv
// Directed bench for par_buffered_sink: always-drain instance and a HOSPITALITY=0 instance.
module tb_par_buffered_sink;

    logic        clk;
    logic        rst_n;
    logic [11:0] item;
    logic        valid;

    logic        m_busy;
    logic [2:0]  m_occ;
    logic [7:0]  m_last;
    logic [3:0]  m_rx;
    logic [3:0]  m_mis;

    logic        h_busy;
    logic [2:0]  h_occ;
    logic [7:0]  h_last;
    logic [15:0] h_rx;
    logic [15:0] h_mis;

    logic [15:0] m_lfsr;

    int total = 0;
    int bad   = 0;

    par_buffered_sink #(
        .ID(3), .HOSPITALITY(255), .MODE(0), .DEPTH(4),
        .PAYLOAD_W(8), .ADDR_W(4), .CNT_W(4)
    ) u_m0 (
        .clk(clk), .reset(rst_n), .item_in(item), .valid(valid),
        .channel_busy(m_busy), .occupancy(m_occ), .last_payload(m_last),
        .rx_count(m_rx), .misroute_count(m_mis)
    );

    par_buffered_sink #(
        .ID(1), .HOSPITALITY(0), .MODE(1), .DEPTH(4),
        .PAYLOAD_W(8), .ADDR_W(4), .CNT_W(16)
    ) u_h0 (
        .clk(clk), .reset(rst_n), .item_in(item), .valid(valid),
        .channel_busy(h_busy), .occupancy(h_occ), .last_payload(h_last),
        .rx_count(h_rx), .misroute_count(h_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR for u_h0: seed {8'h01, 8'hA5}, taps 16,14,13,11
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'h01A5;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic do_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        item  = 'x;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        item  = 'x;
        #1;
        total++; if (m_occ !== 3'd0 || m_busy !== 1'b0) begin
            bad++; $display("FAIL reset_m_occ_busy got=%0d/%0b exp=0/0", m_occ, m_busy);
        end
        total++; if (m_rx !== 4'd0 || m_mis !== 4'd0 || m_last !== 8'd0) begin
            bad++; $display("FAIL reset_m_cnt got=%0d/%0d/%0d exp=0/0/0", m_rx, m_mis, m_last);
        end
        total++; if (h_occ !== 3'd0 || h_busy !== 1'b0) begin
            bad++; $display("FAIL reset_h_occ_busy got=%0d/%0b exp=0/0", h_occ, h_busy);
        end
        total++; if (h_rx !== 16'd0 || h_mis !== 16'd0 || h_last !== 8'd0) begin
            bad++; $display("FAIL reset_h_cnt got=%0d/%0d/%0d exp=0/0/0", h_rx, h_mis, h_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mode0_stream();
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            valid = 1'b1;
            item  = {8'(k), 4'd3};
            @(posedge clk); #1;
            total++; if (m_occ !== 3'd1 || m_busy !== 1'b0 || m_last !== 8'(k - 1)) begin
                bad++; $display("FAIL stream k=%0d got occ=%0d busy=%0b last=%0d exp occ=1 busy=0 last=%0d",
                                k, m_occ, m_busy, m_last, k - 1);
            end
        end
        valid = 1'b0;
        item  = 'x;
        @(posedge clk); #1;
        total++; if (m_occ !== 3'd0 || m_last !== 8'd10) begin
            bad++; $display("FAIL stream_end got occ=%0d last=%0d exp occ=0 last=10", m_occ, m_last);
        end
        total++; if (m_rx !== 4'd10 || m_mis !== 4'd0) begin
            bad++; $display("FAIL stream_cnt got rx=%0d mis=%0d exp rx=10 mis=0", m_rx, m_mis);
        end
        // Empty FIFO: no pop even though drain is always enabled
        @(posedge clk); #1;
        total++; if (m_occ !== 3'd0 || m_last !== 8'd10) begin
            bad++; $display("FAIL stream_idle got occ=%0d last=%0d exp occ=0 last=10", m_occ, m_last);
        end
    endtask

    task automatic test_fill();
        do_reset();
        valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            item = {8'(8'h10 + k), 4'd1};
            @(posedge clk); #1;
            total++; if (h_occ !== 3'((k > 4) ? 4 : k) || h_busy !== (k >= 4)
                         || h_rx !== 16'((k > 4) ? 4 : k)) begin
                bad++; $display("FAIL fill k=%0d got occ=%0d busy=%0b rx=%0d", k, h_occ, h_busy, h_rx);
            end
        end
    endtask

    task automatic test_drain_from_full();
        int occ_m  = 4;
        bit busy_m = 1'b1;
        int rx_m   = 4;
        int pops   = 0;
        int after  = 0;
        bit d;
        bit p;
        bit q;
        valid = 1'b1;
        item  = {8'h20, 4'd1};
        for (int c = 0; c < 3000 && after < 4; c++) begin
            d = (m_lfsr[7:0] == 8'h00);
            p = !busy_m;
            q = d && (occ_m != 0);
            @(posedge clk); #1;
            occ_m  = occ_m + int'(p) - int'(q);
            busy_m = (occ_m == 4);
            rx_m   = rx_m + int'(p);
            if (q) pops++;
            if (pops > 0) after++;
            total++; if (h_occ !== 3'(occ_m) || h_busy !== busy_m) begin
                bad++; $display("FAIL drain c=%0d got occ=%0d busy=%0b exp occ=%0d busy=%0b",
                                c, h_occ, h_busy, occ_m, busy_m);
            end
        end
        total++; if (pops == 0) begin
            bad++; $display("FAIL drain_timeout got pops=0 exp pops>0");
        end
        total++; if (h_rx !== 16'(rx_m)) begin
            bad++; $display("FAIL drain_rx got=%0d exp=%0d", h_rx, rx_m);
        end
        total++; if (h_last !== 8'h11) begin
            bad++; $display("FAIL drain_last got=%0h exp=11", h_last);
        end
        valid = 1'b0;
        item  = 'x;
    endtask

    task automatic test_misroute();
        logic [3:0] dests [3];
        dests[0] = 4'd3;
        dests[1] = 4'd3;
        dests[2] = 4'd5;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            valid = 1'b1;
            item  = {8'(8'h40 + k), dests[k]};
            @(posedge clk); #1;
        end
        valid = 1'b0;
        item  = 'x;
        repeat (2) @(posedge clk);
        #1;
        total++; if (m_rx !== 4'd3 || m_mis !== 4'd1) begin
            bad++; $display("FAIL misroute got rx=%0d mis=%0d exp rx=3 mis=1", m_rx, m_mis);
        end
        total++; if (m_last !== 8'h42 || m_occ !== 3'd0) begin
            bad++; $display("FAIL misroute_last got last=%0h occ=%0d exp last=42 occ=0", m_last, m_occ);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        valid = 1'b1;
        item  = {8'h77, 4'd5};
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 14) begin
                total++; if (m_rx !== 4'd14) begin
                    bad++; $display("FAIL sat_mid got=%0d exp=14", m_rx);
                end
            end
        end
        valid = 1'b0;
        item  = 'x;
        total++; if (m_rx !== 4'd15 || m_mis !== 4'd15) begin
            bad++; $display("FAIL saturate got rx=%0d mis=%0d exp rx=15 mis=15", m_rx, m_mis);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            item = {8'(8'h50 + k), 4'd2};
            @(posedge clk); #1;
        end
        total++; if (h_occ !== 3'd3 || h_rx !== 16'd3 || h_mis !== 16'd3) begin
            bad++; $display("FAIL burst_pre got occ=%0d rx=%0d mis=%0d exp 3/3/3", h_occ, h_rx, h_mis);
        end
        valid = 1'b0;
        item  = 'x;
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (h_occ !== 3'd0 || h_busy !== 1'b0 || h_rx !== 16'd0 || h_mis !== 16'd0) begin
            bad++; $display("FAIL burst_reset got occ=%0d busy=%0b rx=%0d mis=%0d exp 0/0/0/0",
                            h_occ, h_busy, h_rx, h_mis);
        end
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b1;
        item  = {8'h66, 4'd1};
        @(posedge clk); #1;
        valid = 1'b0;
        item  = 'x;
        total++; if (h_rx !== 16'd1 || h_occ !== 3'd1 || h_mis !== 16'd0) begin
            bad++; $display("FAIL burst_after got rx=%0d occ=%0d mis=%0d exp 1/1/0", h_rx, h_occ, h_mis);
        end
    endtask

    initial begin
        test_reset();
        test_mode0_stream();
        test_fill();
        test_drain_from_full();
        test_misroute();
        test_saturate();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
